i2s_receiver: RTL and testbench

- I2S capture block: the reader for the I2S sender's writer. It takes external codec/ADC audio (bclk, lrck, data) and assembles stereo frames in the mon_clk domain.
- It buffers frames in a small FIFO and presents {left,right} 32-bit words with valid/ready to the packet encoder/Sender path toward the monitor link.
- Serial inputs are treated as asynchronous data and are synchronized internally. There is a single clock domain.

---
 rtl/nextasic_audio_pkg.sv | 14 +
 rtl/audio_frame_fifo.sv | 54 +++++
 rtl/i2s_receiver.sv | 136 +++++++++++++
 tb/tb_i2s_receiver.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nextasic_audio_pkg.sv
// rtl/nextasic_audio_pkg.sv - shared audio capture types and widths
package nextasic_audio_pkg;

  localparam int SAMPLE_BITS_DEFAULT = 16;
  localparam int FRAME_BITS          = 2 * SAMPLE_BITS_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LEFT,
    RIGHT
  } rx_state_t;

endpackage

// File: rtl/audio_frame_fifo.sv
// rtl/audio_frame_fifo.sv - synchronous frame FIFO; head reads as zero while empty
module audio_frame_fifo
  import nextasic_audio_pkg::*;
#(
  parameter int WIDTH = FRAME_BITS,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W + 1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S capture into a {left,right} frame FIFO
// Optional short-frame counter output err_count under I2S_RX_ERR_CNT_EN.
module i2s_receiver
  import nextasic_audio_pkg::*;
#(
  parameter int SAMPLE_BITS = SAMPLE_BITS_DEFAULT,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                     mon_clk,
  input  logic                     reset,
  input  logic                     capture_en,
  input  logic                     i2s_bclk,
  input  logic                     i2s_lrck,
  input  logic                     i2s_data,
  output logic                     sample_valid,
  output logic [2*SAMPLE_BITS-1:0] sample_data,
  input  logic                     sample_ready,
  output logic                     overflow
`ifdef I2S_RX_ERR_CNT_EN
  ,
  output logic [7:0]               err_count
`endif
);

  localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SAMPLE_BITS);

  logic [1:0]             bclk_sync, lrck_sync, data_sync;
  logic                   bclk_prev, lrck_prev;
  logic [CNT_W-1:0]       bit_cnt;
  logic [SAMPLE_BITS-1:0] left_sr, right_sr;
  logic                   left_ok;
  rx_state_t              state, state_next;
  logic                   bclk_rise, boundary, fall_bnd, rise_bnd;
  logic                   push, pop, fifo_full, fifo_empty;
`ifdef I2S_RX_ERR_CNT_EN
  logic                   short_frame;
`endif

  assign bclk_rise = bclk_sync[1] & ~bclk_prev;
  assign boundary  = bclk_rise & (lrck_sync[1] != lrck_prev);
  assign fall_bnd  = boundary & ~lrck_sync[1];
  assign rise_bnd  = boundary & lrck_sync[1];

  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      data_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
      bit_cnt   <= '0;
      left_sr   <= '0;
      right_sr  <= '0;
      left_ok   <= 1'b0;
      state     <= IDLE;
    end else begin
      bclk_sync <= {bclk_sync[0], i2s_bclk};
      lrck_sync <= {lrck_sync[0], i2s_lrck};
      data_sync <= {data_sync[0], i2s_data};
      bclk_prev <= bclk_sync[1];
      state     <= state_next;
      if (bclk_rise) begin
        lrck_prev <= lrck_sync[1];
        // the bit sampled on a boundary still belongs to the previous slot
        if (boundary) begin
          bit_cnt <= '0;
        end else if (bit_cnt < FULL_CNT) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (lrck_sync[1]) right_sr <= {right_sr[SAMPLE_BITS-2:0], data_sync[1]};
          else              left_sr  <= {left_sr[SAMPLE_BITS-2:0], data_sync[1]};
        end
      end
      if (state == LEFT && rise_bnd) left_ok <= (bit_cnt == FULL_CNT);
    end
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
`ifdef I2S_RX_ERR_CNT_EN
    short_frame = 1'b0;
`endif
    if (!capture_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:  state_next = SYNC;
        SYNC:  if (fall_bnd) state_next = LEFT;
        LEFT:  if (rise_bnd) state_next = RIGHT;
        RIGHT: begin
          if (fall_bnd) begin
            state_next = LEFT;
            if (left_ok && bit_cnt == FULL_CNT) push = 1'b1;
`ifdef I2S_RX_ERR_CNT_EN
            else short_frame = 1'b1;
`endif
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign sample_valid = ~fifo_empty;
  assign pop          = sample_valid & sample_ready;

  audio_frame_fifo #(
    .WIDTH (2 * SAMPLE_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (mon_clk),
    .rst       (reset),
    .push      (push),
    .push_data ({left_sr, right_sr}),
    .pop       (pop),
    .pop_data  (sample_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset)                           overflow <= 1'b0;
    else if (!capture_en)                overflow <= 1'b0;
    else if (push && fifo_full && !pop)  overflow <= 1'b1;
  end

`ifdef I2S_RX_ERR_CNT_EN
  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset)                                    err_count <= '0;
    else if (!capture_en)                         err_count <= '0;
    else if (short_frame && err_count != 8'hFF)   err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - randomized scoreboard bench for i2s_receiver
module tb_i2s_receiver;

  localparam int SB    = 16;
  localparam int DEPTH = 4;

  logic        mon_clk, reset, capture_en;
  logic        i2s_bclk, i2s_lrck, i2s_data;
  logic        sample_valid, sample_ready, overflow;
  logic [31:0] sample_data;
`ifdef I2S_RX_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  i2s_receiver #(.SAMPLE_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
    .mon_clk      (mon_clk),
    .reset        (reset),
    .capture_en   (capture_en),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_data     (i2s_data),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .overflow     (overflow)
`ifdef I2S_RX_ERR_CNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  initial mon_clk = 1'b0;
  always #5 mon_clk = ~mon_clk;

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Frame-level reference: a frame is a left slot following a falling lrck
  // edge seen while enabled, then a right slot; it is accepted when both
  // slots carry at least SB bits, and lands in a FIFO of DEPTH entries.
  logic [31:0] exp_q[$];
  bit          m_lr, m_armed, m_got_right, sim_pop;
  int          m_ln, m_rn, exp_err;
  logic [15:0] m_lv, m_rv;

  function automatic logic [15:0] slot_val(logic [31:0] w, int n);
    logic [31:0] t;
    t = (n >= SB) ? (w >> (n - SB)) : 32'h0;
    return t[15:0];
  endfunction

  task automatic frame_done();
    if (m_ln >= SB && m_rn >= SB) begin
      if (exp_q.size() < DEPTH + int'(sim_pop)) exp_q.push_back({m_lv, m_rv});
    end else if (exp_err < 255) begin
      exp_err++;
    end
  endtask

  task automatic model_slot(bit lr, logic [31:0] w, int n);
    if (lr != m_lr && !lr && capture_en) begin
      if (m_armed && m_got_right) frame_done();
      m_armed = 1; m_got_right = 0; m_ln = n; m_lv = slot_val(w, n);
    end else if (lr != m_lr && lr && m_armed) begin
      m_got_right = 1; m_rn = n; m_rv = slot_val(w, n);
    end
    m_lr = lr;
  endtask

  task automatic model_disable();
    m_armed = 0; m_got_right = 0; exp_err = 0;
  endtask

  // Consumer: ready pattern per mode, plus a one-cycle forced pulse.
  int ready_mode = 0;
  bit force_ready = 0;
  initial begin
    sample_ready = 1'b0;
    forever begin
      @(posedge mon_clk);
      #1;
      if (force_ready)          sample_ready = 1'b1;
      else if (ready_mode == 1) sample_ready = 1'b1;
      else if (ready_mode == 2) sample_ready = 1'($urandom_range(0, 1));
      else                      sample_ready = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every accepted frame, checks head stability.
  logic [31:0] held;
  bit          held_v = 0;
  always @(negedge mon_clk) begin
    if (reset) begin
      held_v = 0;
    end else begin
      if (held_v && sample_valid) check("head_stable", sample_data, held);
      if (sample_valid && sample_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %h, expected no frame", sample_data);
        end else begin
          check("frame", sample_data, exp_q.pop_front());
        end
        held_v = 0;
      end else begin
        held_v = sample_valid;
        held   = sample_data;
      end
    end
  end

  // action 1: ready pulse exactly in the push cycle; action 2: valid latency check
  task automatic send_bit(bit lr, bit d, int action);
    i2s_bclk = 1'b0; i2s_lrck = lr; i2s_data = d;
    repeat (4) @(negedge mon_clk);
    i2s_bclk = 1'b1;
    if (action == 1) begin
      @(posedge mon_clk); @(posedge mon_clk);
      force_ready = 1;
      @(posedge mon_clk);
      force_ready = 0;
    end else if (action == 2) begin
      @(posedge mon_clk); @(posedge mon_clk); @(negedge mon_clk);
      check("valid_before_push", sample_valid, 0);
      @(negedge mon_clk);
      check("valid_after_push", sample_valid, 1);
      check("basic_data", sample_data, 32'h1234ABCD);
    end
    repeat (4) @(negedge mon_clk);
  endtask

  task automatic send_slot(bit lr, logic [31:0] w, int n, int action = 0);
    model_slot(lr, w, n);
    send_bit(lr, 1'($urandom_range(0, 1)), action);
    for (int i = n - 1; i >= 0; i--) send_bit(lr, w[i], 0);
  endtask

  task automatic send_frame(logic [31:0] l, int nl, logic [31:0] r, int nr);
    send_slot(0, l, nl);
    send_slot(1, r, nr);
  endtask

  task automatic begin_test(int mode);
    ready_mode = mode;
    capture_en = 1'b1;
    send_slot(1, 32'h0, 2);
  endtask

  task automatic drain();
    int t = 0;
    ready_mode = 1;
    while ((exp_q.size() != 0 || sample_valid) && t < 400) begin
      @(negedge mon_clk);
      t++;
    end
    check("drain_in_time", 32'(t < 400), 1);
    check("drain_empty", sample_valid, 0);
    ready_mode = 0;
    @(negedge mon_clk);
  endtask

  task automatic end_test();
    capture_en = 1'b0;
    model_disable();
    @(negedge mon_clk);
    check("overflow_cleared", overflow, 0);
`ifdef I2S_RX_ERR_CNT_EN
    check("err_cleared", err_count, 0);
`endif
  endtask

  initial begin
    int p0;
    logic [31:0] l, r;
    int nl, nr;
    reset = 1'b1; capture_en = 1'b0;
    i2s_bclk = 1'b0; i2s_lrck = 1'b0; i2s_data = 1'b0;
    m_lr = 0; m_armed = 0; m_got_right = 0; sim_pop = 0; exp_err = 0;
    repeat (3) @(negedge mon_clk);
    check("reset_valid", sample_valid, 0);
    check("reset_data", sample_data, 0);
    check("reset_overflow", overflow, 0);
`ifdef I2S_RX_ERR_CNT_EN
    check("reset_err", err_count, 0);
`endif
    reset = 1'b0;
    @(negedge mon_clk);

    // basic frame with push latency
    begin_test(0);
    send_frame(32'h1234, 16, 32'hABCD, 16);
    send_slot(0, 32'h5A5A, 16, 2);
    drain();
    end_test();

    // 32-bit slots, only the top SB bits are kept
    begin_test(0);
    send_frame(32'hFFFF0000, 32, 32'h0001FFFF, 32);
    send_slot(0, 32'h0, 16);
    check("long_data", sample_data, 32'hFFFF0001);
    drain();
    end_test();

    // short right slot is dropped
    begin_test(0);
    send_frame(32'h1111, 16, 32'h0222, 10);
    send_slot(0, 32'h0, 16);
    check("short_no_push", sample_valid, 0);
`ifdef I2S_RX_ERR_CNT_EN
    check("short_err_count", err_count, 1);
`endif
    drain();
    end_test();

    // random frames, random lengths, random consumer
    begin_test(2);
    for (int k = 0; k < 10; k++) begin
      l = $urandom; r = $urandom;
      nl = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(16, 24);
      nr = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(16, 24);
      send_frame(l, nl, r, nr);
    end
    send_slot(0, 32'h0, 16);
`ifdef I2S_RX_ERR_CNT_EN
    check("random_err_count", err_count, exp_err);
`endif
    drain();
    end_test();

    // overflow: fifth frame dropped
    begin_test(0);
    for (int k = 0; k < 5; k++) send_frame(32'h100 + k, 16, 32'h200 + k, 16);
    send_slot(0, 32'h0, 16);
    check("overflow_set", overflow, 1);
    p0 = pops;
    drain();
    check("overflow_drain_count", pops - p0, 4);
    check("overflow_sticky", overflow, 1);
    end_test();

    // full FIFO with a pop in the push cycle
    begin_test(0);
    for (int k = 0; k < 5; k++) send_frame(32'h300 + k, 16, 32'h400 + k, 16);
    sim_pop = 1;
    p0 = pops;
    send_slot(0, 32'h0, 16, 1);
    sim_pop = 0;
    check("full_pop_no_overflow", overflow, 0);
    check("full_pop_one_popped", pops - p0, 1);
    drain();
    check("full_pop_total", pops - p0, 5);
    end_test();

    // capture_en dropped mid-left, re-enabled mid-left
    begin_test(0);
    send_slot(0, 32'hDE, 8);
    capture_en = 1'b0;
    model_disable();
    send_slot(0, 32'hAD, 8);
    send_slot(1, 32'hBEEF, 16);
    send_slot(0, 32'h12, 8);
    capture_en = 1'b1;
    send_slot(0, 32'h34, 8);
    send_slot(1, 32'hCAFE, 16);
    send_slot(0, 32'h7777, 16);
    check("reenable_no_push", sample_valid, 0);
    send_slot(1, 32'h8888, 16);
    send_slot(0, 32'h0, 16);
    check("reenable_push", sample_valid, 1);
    drain();
    end_test();

    // asynchronous reset mid-frame
    begin_test(0);
    send_frame(32'hAAAA, 16, 32'h5555, 16);
    send_frame(32'h0F0F, 16, 32'h0, 0);
    send_slot(1, 32'hF0, 8);
    check("pre_reset_valid", sample_valid, 1);
    @(negedge mon_clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_valid", sample_valid, 0);
    check("async_reset_data", sample_data, 0);
    check("async_reset_overflow", overflow, 0);
    exp_q.delete();
    model_disable();
    m_lr = 0;
    i2s_bclk = 1'b0;
    repeat (3) @(negedge mon_clk);
    reset = 1'b0;
    capture_en = 1'b0;
    @(negedge mon_clk);
    check("post_reset_valid", sample_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
